// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO behind uart_rx with a valid/ready head port,
// a registered fill level and a sticky overflow flag.
// Optional feature macro: UART_RX_FIFO_BREAK_EN (stores a BREAK bit per entry).
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             uart_rx_valid,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_rx_break,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_break,
    output logic [LVL_W-1:0] fill_level,
    output logic             full,
    output logic             overflow,
    input  logic             overflow_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef UART_RX_FIFO_BREAK_EN
    localparam int unsigned ENT_W = 9;
`else
    localparam int unsigned ENT_W = 8;
`endif

    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] entry;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic             full_nxt;
    logic             valid_nxt;
    logic             overflow_nxt;
    logic             accept;
    logic             push;
    logic             pop;
    logic             drop;

    // Push/pop/drop decisions and next pointer, level and flag values.
    always_comb begin
        pop    = out_valid && out_ready;
`ifdef UART_RX_FIFO_BREAK_EN
        accept = uart_rx_valid;
        entry  = {uart_rx_break, uart_rx_data};
`else
        // BREAK pulses are silently ignored when entries carry no break bit.
        accept = uart_rx_valid && !uart_rx_break;
        entry  = uart_rx_data;
`endif
        push       = accept && (!full || pop);
        drop       = accept && full && !pop;
        wr_ptr_nxt = push ? wr_ptr + (AW + 1)'(1) : wr_ptr;
        rd_ptr_nxt = pop  ? rd_ptr + (AW + 1)'(1) : rd_ptr;
        level_nxt  = LVL_W'(wr_ptr_nxt - rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                     (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
        valid_nxt  = (wr_ptr_nxt != rd_ptr_nxt);
        // A drop in the same cycle as a clear keeps the flag set.
        overflow_nxt = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow);
    end

    // Pointer, status and overflow registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            full       <= 1'b0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            fill_level <= level_nxt;
            full       <= full_nxt;
            out_valid  <= valid_nxt;
            overflow   <= overflow_nxt;
        end
    end

    // Entry storage; contents are never reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= entry;
        end
    end

    // Head entry read, masked while the FIFO is empty.
    always_comb begin
        head     = mem[rd_ptr[AW-1:0]];
        out_data = out_valid ? head[7:0] : 8'h00;
`ifdef UART_RX_FIFO_BREAK_EN
        out_break = out_valid && head[8];
`else
        out_break = 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with DEPTH=4.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = 3;

    logic             clk = 1'b0;
    logic             resetn;
    logic             uart_rx_valid;
    logic [7:0]       uart_rx_data;
    logic             uart_rx_break;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_break;
    logic [LVL_W-1:0] fill_level;
    logic             full;
    logic             overflow;
    logic             overflow_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .resetn(resetn),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .uart_rx_break(uart_rx_break),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_break(out_break),
        .fill_level(fill_level), .full(full),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        uart_rx_valid = 1'b1;
        uart_rx_data  = d;
        step();
        uart_rx_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        uart_rx_valid = 1'b0; uart_rx_data = 8'h00; uart_rx_break = 1'b0;
        out_ready = 1'b0; overflow_clr = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
        checks++; if (out_break !== 1'b0) begin errors++; $display("FAIL reset_break got %b exp 0", out_break); end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fill_level); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        @(negedge clk);
        resetn = 1'b1;
        step();
    endtask

    task automatic test_single();
        push(8'hA5);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", out_data); end
        checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL single_level got %0d exp 1", fill_level); end
        pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL single_mask got %h exp 00", out_data); end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL single_level0 got %0d exp 0", fill_level); end
    endtask

    task automatic test_order();
        logic [7:0] exp_d;
        push(8'h01); step(); push(8'h02); step(); push(8'h03);
        step();
        checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL order_hold got %h exp 01", out_data); end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_d = 8'(i);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin
                errors++; $display("FAIL order_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d);
            end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
        push(8'h14);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fill_level); end
        // Drop together with clear: set wins.
        overflow_clr = 1'b1;
        push(8'h15);
        overflow_clr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_prio got %b exp 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'(8'h10 + i);
            checks++;
            if (out_data !== exp_d) begin errors++; $display("FAIL ovf_pop%0d got %h exp %h", i, out_data, exp_d); end
            pop();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", overflow); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL pp_full got %b exp 1", full); end
        out_ready = 1'b1;
        push(8'h24);
        out_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf got %b exp 0", overflow); end
        checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL pp_level got %0d exp 4", fill_level); end
        for (int i = 1; i <= 4; i++) begin
            exp_d = 8'(8'h20 + i);
            checks++;
            if (out_data !== exp_d) begin errors++; $display("FAIL pp_drain%0d got %h exp %h", i, out_data, exp_d); end
            pop();
        end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL pp_level0 got %0d exp 0", fill_level); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d;
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            exp_d = 8'(i);
            push(exp_d);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin
                errors++; $display("FAIL wrap_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d);
            end
            pop();
        end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL wrap_level got %0d exp 0", fill_level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_break();
        uart_rx_break = 1'b1;
        push(8'h00);
        uart_rx_break = 1'b0;
        step();
        push(8'h41);
`ifdef UART_RX_FIFO_BREAK_EN
        checks++; if (fill_level !== 3'd2) begin errors++; $display("FAIL brk_level got %0d exp 2", fill_level); end
        checks++; if (out_break !== 1'b1 || out_data !== 8'h00) begin
            errors++; $display("FAIL brk_head got b=%b d=%h exp b=1 d=00", out_break, out_data); end
        pop();
        checks++; if (out_break !== 1'b0 || out_data !== 8'h41) begin
            errors++; $display("FAIL brk_next got b=%b d=%h exp b=0 d=41", out_break, out_data); end
`else
        checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL brk_level got %0d exp 1", fill_level); end
        checks++; if (out_break !== 1'b0 || out_data !== 8'h41) begin
            errors++; $display("FAIL brk_head got b=%b d=%h exp b=0 d=41", out_break, out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL brk_ovf got %b exp 0", overflow); end
`endif
        pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL brk_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        push(8'h55); push(8'h66); push(8'h77); push(8'h88); push(8'h99);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf got %b exp 1", overflow); end
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL mid_head got v=%b d=%h exp v=0 d=00", out_valid, out_data); end
        checks++; if (fill_level !== 3'd0 || full !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_status got l=%0d f=%b o=%b exp 0 0 0", fill_level, full, overflow); end
        @(negedge clk);
        resetn = 1'b1;
        step();
        push(8'hC3);
        checks++; if (fill_level !== 3'd1 || out_data !== 8'hC3) begin
            errors++; $display("FAIL mid_after got l=%0d d=%h exp 1 c3", fill_level, out_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_overflow();
        test_full_pushpop();
        test_wrap();
        test_break();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of `uart_rx`. It captures each single-cycle `uart_rx_valid` pulse with its `uart_rx_data` byte into a circular FIFO. It presents the bytes in order to the host logic over a valid/ready handshake, and reports fill level and a sticky overflow flag. This decouples the line-rate receiver from consumers that cannot accept every byte the cycle it arrives.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥2.
- `LVL_W`, $clog2(DEPTH)+1, width of `fill_level`.

- `clk` in 1, system clock; all logic on rising edge.
- `resetn` in 1, reset; asynchronous, active-low.
- `uart_rx_valid` in 1, one-cycle pulse: `uart_rx_data` holds a received byte.
- `uart_rx_data` in 8, received byte, sampled only when `uart_rx_valid`=1.
- `uart_rx_break` in 1, qualifies `uart_rx_valid`: the byte is a BREAK (data 8'h00).
- `out_valid` out 1, head entry available.
- `out_ready` in 1, consumer accepts the head entry when `out_valid`=1.
- `out_data` out 8, head byte; forced 8'h00 when `out_valid`=0.
- `out_break` out 1, head entry is a BREAK marker; 0 when `out_valid`=0.
- `fill_level` out LVL_W, number of stored entries, 0..DEPTH.
- `full` out 1, `fill_level`==DEPTH.
- `overflow` out 1, sticky: a byte was dropped because the FIFO was full.
- `overflow_clr` in 1, synchronous clear of `overflow`.

## Operation
- Storage: DEPTH-entry array (9 bits/entry with `UART_RX_FIFO_BREAK_EN`, else 8); memory contents not reset.
- Pointers: `wr_ptr`, `rd_ptr`, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ. `fill_level` = `wr_ptr` − `rd_ptr` (modulo 2^LVL_W), registered.
- Read: a pop occurs when `out_valid && out_ready`, and `rd_ptr` increments. `out_ready` with `out_valid`=0 has no effect.
- Write: a push occurs when `uart_rx_valid`=1 and (`full`=0 or a pop occurs in the same cycle). The entry is stored at `wr_ptr` and `wr_ptr` increments.
- Drop: `uart_rx_valid`=1, `full`=1, and no pop in the same cycle. The byte is discarded, the pointers are unchanged, and `overflow` is set on the next edge.
- `overflow` priority: a set in the same cycle as `overflow_clr` wins, so the flag stays 1.
- Simultaneous push and pop: `fill_level` is unchanged. Both pointers advance.
- Pointer wrap: pointers roll from 2·DEPTH−1 to 0 with no special handling.
- Reset mid-operation: all contents are logically discarded; all outputs return to their reset values.

## Timing
- Reset values: `out_valid`=0, `out_data`=8'h00, `out_break`=0, `fill_level`=0, `full`=0, `overflow`=0.
- Write latency: a push on edge N makes the entry visible at the head. `out_valid` rises after edge N when the FIFO was empty; there is no same-cycle bypass.
- Head outputs (`out_data`, `out_break`) are a combinational read of `mem[rd_ptr]`, masked by `out_valid`. They remain stable while `out_valid`=1 and `out_ready`=0.
- A pop on edge N presents the next entry after edge N, so back-to-back pops sustain one entry per cycle.
- `full`, `fill_level` and `overflow` are registered and update one edge after the causing event.
- `uart_rx_valid` is never asserted on consecutive cycles by `uart_rx`, but the FIFO still accepts one push per cycle.

## Configuration
- `UART_RX_FIFO_BREAK_EN` defined:
  - Each entry carries a break bit equal to `uart_rx_break` at push.
  - BREAK bytes are stored like data and occupy an entry.
  - `out_break` reflects the head entry's break bit.
- `UART_RX_FIFO_BREAK_EN` undefined:
  - Entries are 8 bits.
  - Any `uart_rx_valid` pulse with `uart_rx_break`=1 is discarded: no push, no overflow.
  - `out_break` is tied to 0.

## Test plan
- Reset with `DEPTH`=4: all outputs at their reset values. Push 8'hA5 → next cycle `out_valid`=1, `out_data`=8'hA5, `fill_level`=1. Pop → `out_valid`=0, `out_data`=8'h00.
- Order: push 8'h01, 8'h02, 8'h03 with `out_ready`=0, then hold `out_ready`=1 → outputs 01, 02, 03 on consecutive cycles, then `out_valid`=0.
- Overflow: push 8'h10..8'h14 into `DEPTH`=4 without popping → `full`=1, `overflow`=1, and 8'h14 is dropped. Pops yield 10..13. Pulsing `overflow_clr` → `overflow`=0.
- Full with simultaneous push and pop: full with 8'h20..8'h23, push 8'h24 in the pop cycle → no overflow, `fill_level` stays 4. Drain yields 21..24.
- Wrap: perform 3·DEPTH+1 single push/pop pairs with values 0..12 → each value is read back in order and `fill_level` returns to 0.
- Break: `uart_rx_valid`=1 with `uart_rx_break`=1 and data 8'h00, then push 8'h41.
  - With the macro: `out_break`=1 for the first entry and 0 for 8'h41.
  - Without the macro: only 8'h41 appears, with `fill_level`=1.
